// File: rtl/spi_slave.sv
// spi_slave: SPI slave supporting all four CPOL/CPHA modes, oversampled by clk.
// sck, ss_n and mosi are brought into the clk domain through 2-flop
// synchronizers and edges are detected on the synchronized sck.
// Optional build macro SPI_SLAVE_FRAME_ERR_EN adds a frame_err pulse output
// that flags words abandoned mid-transfer.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ckp,
    input  logic              cph,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] received_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        sck_sync, ss_sync, mosi_sync;
    logic              sck_prev, ss_prev;
    logic              sck_s, ss_s, mosi_s;
    logic              lead, trail, sample_edge, shift_edge;
    logic              active, sample, last, do_shift, load, ss_fall;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    // Set at each load point; blocks the one shift edge that belongs to the
    // previous word (cph=0 trailing) or precedes the first bit (cph=1 leading).
    logic              skip_q;

    assign sck_s  = sck_sync[1];
    assign ss_s   = ss_sync[1];
    assign mosi_s = mosi_sync[1];

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead        = (sck_prev == ckp) && (sck_s != ckp);
    assign trail       = (sck_prev != ckp) && (sck_s == ckp);
    assign sample_edge = cph ? trail : lead;
    assign shift_edge  = cph ? lead  : trail;
    assign ss_fall     = ss_prev && !ss_s;

    assign active   = (state_q == SHIFT);
    // A sample coincident with ss_n rising still counts so a final bit completes.
    assign sample   = active && sample_edge;
    assign last     = sample && (bit_cnt == LAST_BIT);
    assign do_shift = active && shift_edge && !skip_q;

    assign miso = active ? tx_sr[DATA_W-1] : 1'b0;
    assign busy = active;

    // Synchronizers plus one history flop each for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= {2{ckp}};
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_prev  <= ckp;
            ss_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            ss_sync   <= {ss_sync[0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sck_prev  <= sck_sync[1];
            ss_prev   <= ss_sync[1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and word load points (transfer start, and after each
    // completed word while ss_n stays low).
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_s)          state_d = IDLE;
                else if (rx_valid) load    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, bit counter and the skip flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            skip_q  <= 1'b0;
        end else if (load) begin
            tx_sr   <= tx_data;
            bit_cnt <= '0;
            skip_q  <= 1'b1;
        end else if (!active || ss_s) begin
            // Idle or aborting: any partial word is dropped.
            bit_cnt <= '0;
        end else begin
            if (sample) begin
                rx_sr   <= {rx_sr[DATA_W-2:0], mosi_s};
                bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
            end
            if (do_shift) tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
            if (lead)     skip_q <= 1'b0;
        end
    end

    // Completed word publish and one-cycle valid strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            received_data <= '0;
            rx_valid      <= 1'b0;
        end else begin
            rx_valid <= last;
            if (last) received_data <= {rx_sr[DATA_W-2:0], mosi_s};
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // Pulse when ss_n drops out of a transfer with a partial word pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_err <= 1'b0;
        else        frame_err <= active && ss_s && (bit_cnt != '0) && !last;
    end
`endif

endmodule
